// File: rtl/gpio_pkg.sv
// Shared constants for the switch/LED MMIO peripheral: bus geometry, register offsets, edge modes.
package gpio_pkg;

  localparam int unsigned BUS_AW = 5;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_BW = 4;

  localparam logic [BUS_AW-1:0] OFF_SW_STATE  = 5'h00;
  localparam logic [BUS_AW-1:0] OFF_SW_EDGE   = 5'h04;
  localparam logic [BUS_AW-1:0] OFF_IRQ_EN    = 5'h08;
  localparam logic [BUS_AW-1:0] OFF_LED_OUT   = 5'h0C;
  localparam logic [BUS_AW-1:0] OFF_LED_BLINK = 5'h10;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Expand byte enables into a per-bit write mask.
  function automatic logic [BUS_DW-1:0] be_mask(input logic [BUS_BW-1:0] be);
    logic [BUS_DW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BUS_BW); i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sw_led_ctrl_if.sv
// CPU MMIO data-port bundle for the switch/LED peripheral.
interface gpio_sw_led_ctrl_if;
  import gpio_pkg::*;

  logic [BUS_AW-1:0] bus_addr;
  logic              bus_wr;
  logic              bus_rd;
  logic [BUS_BW-1:0] bus_be;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (output bus_addr, bus_wr, bus_rd, bus_be, bus_wdata,
                  input  bus_rdata, bus_rvalid);
  modport slave  (input  bus_addr, bus_wr, bus_rd, bus_be, bus_wdata,
                  output bus_rdata, bus_rvalid);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch input: 2-flop synchroniser followed by a consecutive-sample debounce counter.
module sw_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_async,
  output logic stable
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // Any sample matching the accepted value restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_async};
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_q[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_sw_led_ctrl.sv
// Switch/LED MMIO peripheral: debounced switches with sticky edge capture and irq, masked LED writes, per-LED blink.
module gpio_sw_led_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 24,
  parameter int unsigned LED_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned EDGE_MODE       = 2,
  parameter int unsigned BLINK_DIV       = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switch,
  output logic [LED_WIDTH-1:0] led,
  gpio_sw_led_ctrl_if.slave    mmio,
  output logic                 irq
);
  localparam int unsigned BLINK_CW = $clog2(BLINK_DIV);

  logic [SW_WIDTH-1:0]  sw_stable, sw_stable_d, sw_edge, irq_en;
  logic [SW_WIDTH-1:0]  edge_set_c, edge_clr_c;
  logic [LED_WIDTH-1:0] led_out, led_blink;
  logic [BLINK_CW-1:0]  presc;
  logic                 phase;
  logic [BUS_AW-1:0]    off_c;
  logic [BUS_DW-1:0]    wmask_c, rdata_c;
  logic                 wr_edge_c, wr_irq_en_c, wr_led_out_c, wr_led_blink_c;

  for (genvar i = 0; i < int'(SW_WIDTH); i++) begin : gen_db
    sw_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset    (reset),
      .sw_async (switch[i]),
      .stable   (sw_stable[i])
    );
  end

  // Address decode, edge detection and read mux.
  always_comb begin
    off_c          = mmio.bus_addr & 5'b11100;
    wmask_c        = be_mask(mmio.bus_be);
    wr_edge_c      = mmio.bus_wr && (off_c == OFF_SW_EDGE);
    wr_irq_en_c    = mmio.bus_wr && (off_c == OFF_IRQ_EN);
    wr_led_out_c   = mmio.bus_wr && (off_c == OFF_LED_OUT);
    wr_led_blink_c = mmio.bus_wr && (off_c == OFF_LED_BLINK);

    if (EDGE_MODE == EDGE_RISE)      edge_set_c = sw_stable & ~sw_stable_d;
    else if (EDGE_MODE == EDGE_FALL) edge_set_c = ~sw_stable & sw_stable_d;
    else                             edge_set_c = sw_stable ^ sw_stable_d;

    edge_clr_c = wr_edge_c ? SW_WIDTH'(mmio.bus_wdata & wmask_c) : '0;

    case (off_c)
      OFF_SW_STATE:  rdata_c = BUS_DW'(sw_stable);
      OFF_SW_EDGE:   rdata_c = BUS_DW'(sw_edge);
      OFF_IRQ_EN:    rdata_c = BUS_DW'(irq_en);
      OFF_LED_OUT:   rdata_c = BUS_DW'(led_out);
      OFF_LED_BLINK: rdata_c = BUS_DW'(led_blink);
      default:       rdata_c = '0;
    endcase
  end

  // Registers read the pre-write state, so a same-cycle read returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_stable_d     <= '0;
      sw_edge         <= '0;
      irq_en          <= '0;
      led_out         <= '0;
      led_blink       <= '0;
      presc           <= '0;
      phase           <= 1'b0;
      led             <= '0;
      irq             <= 1'b0;
      mmio.bus_rdata  <= '0;
      mmio.bus_rvalid <= 1'b0;
    end else begin
      sw_stable_d <= sw_stable;
      sw_edge     <= (sw_edge & ~edge_clr_c) | edge_set_c;
      if (wr_irq_en_c)
        irq_en <= SW_WIDTH'((BUS_DW'(irq_en) & ~wmask_c) | (mmio.bus_wdata & wmask_c));
      if (wr_led_out_c)
        led_out <= LED_WIDTH'((BUS_DW'(led_out) & ~wmask_c) | (mmio.bus_wdata & wmask_c));
      if (wr_led_blink_c)
        led_blink <= LED_WIDTH'((BUS_DW'(led_blink) & ~wmask_c) | (mmio.bus_wdata & wmask_c));

      if (presc == BLINK_CW'(BLINK_DIV - 1)) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + BLINK_CW'(1);
      end

      led             <= led_out & (~led_blink | {LED_WIDTH{phase}});
      irq             <= |(sw_edge & irq_en);
      mmio.bus_rvalid <= mmio.bus_rd;
      if (mmio.bus_rd) mmio.bus_rdata <= rdata_c;
    end
  end

endmodule

// File: tb/tb_gpio_sw_led_ctrl.sv
// Directed bench for gpio_sw_led_ctrl with a cycle-level behavioural model compared every cycle.
module tb_gpio_sw_led_ctrl;
  localparam int unsigned DEB   = 4;
  localparam int unsigned BDIV  = 4;
  localparam int unsigned EMODE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] switch = '0;
  logic [23:0] led;
  logic        irq;
  int          checks = 0;
  int          failures = 0;
  bit          cmp_on = 1'b0;

  gpio_sw_led_ctrl_if mmio();

  gpio_sw_led_ctrl #(
    .SW_WIDTH(24), .LED_WIDTH(24), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EMODE), .BLINK_DIV(BDIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .switch (switch),
    .led    (led),
    .mmio   (mmio),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: stable flips once the last DEB synchronised samples all disagree with it.
  logic [23:0] m_hist [0:5] = '{default: '0};
  logic [23:0] m_stable = '0, m_stable_d = '0, m_edge = '0, m_irqen = '0;
  logic [23:0] m_ledout = '0, m_blink = '0, m_led = '0;
  logic [23:0] t_all1, t_all0, t_set, t_clr;
  logic [31:0] t_mask, m_rdata = '0;
  logic        m_irq = 1'b0, m_rvalid = 1'b0, m_phase = 1'b0;
  int unsigned m_presc = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return 32'(m_stable);
      3'd1: return 32'(m_edge);
      3'd2: return 32'(m_irqen);
      3'd3: return 32'(m_ledout);
      3'd4: return 32'(m_blink);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) m_hist[i] = '0;
      m_stable = '0; m_stable_d = '0; m_edge = '0; m_irqen = '0;
      m_ledout = '0; m_blink = '0; m_led = '0; m_irq = 1'b0;
      m_rdata = '0; m_rvalid = 1'b0; m_phase = 1'b0; m_presc = 0;
    end else begin
      t_mask = {{8{mmio.bus_be[3]}}, {8{mmio.bus_be[2]}}, {8{mmio.bus_be[1]}}, {8{mmio.bus_be[0]}}};
      if (mmio.bus_rd) m_rdata = model_read(mmio.bus_addr);
      m_rvalid = mmio.bus_rd;
      m_irq = |(m_edge & m_irqen);
      m_led = m_ledout & (~m_blink | {24{m_phase}});
      if (EMODE == 0)      t_set = m_stable & ~m_stable_d;
      else if (EMODE == 1) t_set = ~m_stable & m_stable_d;
      else                 t_set = m_stable ^ m_stable_d;
      t_clr = '0;
      if (mmio.bus_wr) begin
        case (mmio.bus_addr[4:2])
          3'd1: t_clr = 24'(mmio.bus_wdata & t_mask);
          3'd2: m_irqen  = 24'((32'(m_irqen)  & ~t_mask) | (mmio.bus_wdata & t_mask));
          3'd3: m_ledout = 24'((32'(m_ledout) & ~t_mask) | (mmio.bus_wdata & t_mask));
          3'd4: m_blink  = 24'((32'(m_blink)  & ~t_mask) | (mmio.bus_wdata & t_mask));
          default: ;
        endcase
      end
      m_edge = (m_edge & ~t_clr) | t_set;
      t_all1 = m_hist[1] & m_hist[2] & m_hist[3] & m_hist[4];
      t_all0 = ~(m_hist[1] | m_hist[2] | m_hist[3] | m_hist[4]);
      m_stable_d = m_stable;
      m_stable = (m_stable | t_all1) & ~t_all0;
      for (int i = 5; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = switch;
      if (m_presc == BDIV - 1) begin
        m_presc = 0;
        m_phase = ~m_phase;
      end else begin
        m_presc++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_led",    32'(led),             32'(m_led));
      check("model_irq",    32'(irq),             32'(m_irq));
      check("model_rvalid", 32'(mmio.bus_rvalid), 32'(m_rvalid));
      check("model_rdata",  mmio.bus_rdata,       m_rdata);
    end
  end

  task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    mmio.bus_addr = a; mmio.bus_be = be; mmio.bus_wdata = d; mmio.bus_wr = 1'b1;
    @(negedge clk);
    mmio.bus_wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string nm);
    mmio.bus_addr = a; mmio.bus_rd = 1'b1;
    @(negedge clk);
    mmio.bus_rd = 1'b0;
    check({nm, "_rvalid"}, 32'(mmio.bus_rvalid), 32'd1);
    check(nm, mmio.bus_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          toggles;
    logic [3:0]  prev;
    mmio.bus_addr = '0; mmio.bus_wr = 1'b0; mmio.bus_rd = 1'b0;
    mmio.bus_be = '0; mmio.bus_wdata = '0;
    switch = 24'h002436;
    #1 reset = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(mmio.bus_rvalid), 32'h0);
    check("rst_rdata", mmio.bus_rdata, 32'h0);

    // 1: release and let the held switches settle
    reset = 1'b1;
    rd_chk(5'h00, 32'h0, "sw_state_early");
    repeat (8) @(negedge clk);
    rd_chk(5'h00, 32'h002436, "sw_state");
    rd_chk(5'h04, 32'h002436, "sw_edge_init");
    wr(5'h04, 4'hF, 32'hFFFF_FFFF);
    rd_chk(5'h04, 32'h0, "sw_edge_clr");

    // 2: bounce on bit 0
    switch[0] = 1'b1; repeat (2) @(negedge clk);
    switch[0] = 1'b0; repeat (2) @(negedge clk);
    switch[0] = 1'b1; repeat (3) @(negedge clk);
    rd_chk(5'h00, 32'h002436, "sw_state_bounce");
    repeat (6) @(negedge clk);
    rd_chk(5'h00, 32'h002437, "sw_state_settled");
    rd_chk(5'h04, 32'h1, "sw_edge_single");
    switch = 24'h002436;
    repeat (10) @(negedge clk);
    wr(5'h04, 4'hF, 32'hFFFF_FFFF);
    rd_chk(5'h04, 32'h0, "sw_edge_clr2");

    // 3: irq timing, W1C, set-wins
    wr(5'h08, 4'hF, 32'h1);
    rd_chk(5'h08, 32'h1, "irq_en");
    switch = 24'h003253;
    repeat (7) @(negedge clk);
    check("irq_pre", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'h1);
    wr(5'h04, 4'h1, 32'h1);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_w1c", 32'(irq), 32'h0);
    switch = 24'h003252;
    repeat (6) @(negedge clk);
    wr(5'h04, 4'h1, 32'h1);
    rd_chk(5'h04, 32'h001665, "edge_set_wins");

    // 4: byte-masked LED write, ignored writes
    wr(5'h0C, 4'b0011, 32'hFFFF_FFFF);
    @(negedge clk);
    check("led_be", 32'(led), 32'h00FFFF);
    rd_chk(5'h0C, 32'h0000FFFF, "led_out_rb");
    wr(5'h00, 4'hF, 32'hFFFF_FFFF);
    wr(5'h18, 4'hF, 32'hFFFF_FFFF);
    rd_chk(5'h00, 32'h003252, "sw_state_ro");
    rd_chk(5'h18, 32'h0, "unused_off");
    rd_chk(5'h10, 32'h0, "blink_zero");

    // 5: blink
    wr(5'h0C, 4'hF, 32'h000F_FFFF);
    wr(5'h10, 4'hF, 32'h0000_0F00);
    @(negedge clk);
    toggles = 0;
    prev = led[11:8];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("blink_steady_bits", 32'(led & 24'hFFF0FF), 32'h0FF0FF);
      if (led[11:8] != prev) toggles++;
      prev = led[11:8];
    end
    check("blink_toggles", 32'(toggles), 32'd4);
    wr(5'h10, 4'hF, 32'h0);
    @(negedge clk);
    check("blink_off", 32'(led), 32'h0FFFFF);

    // 6: asynchronous reset mid-debounce and mid-blink
    wr(5'h10, 4'hF, 32'h0000_0F00);
    switch = 24'h000000;
    repeat (3) @(negedge clk);
    mmio.bus_addr = 5'h0C; mmio.bus_rd = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_irq", 32'(irq), 32'h1);
    check("pre_rst_rvalid", 32'(mmio.bus_rvalid), 32'h1);
    reset = 1'b0;
    mmio.bus_rd = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    check("async_rvalid", 32'(mmio.bus_rvalid), 32'h0);
    check("async_rdata", mmio.bus_rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_irq", 32'(irq), 32'h0);
    check("post_rst_led", 32'(led), 32'h0);
    rd_chk(5'h04, 32'h0, "post_rst_edge");
    rd_chk(5'h08, 32'h0, "post_rst_irq_en");
    rd_chk(5'h00, 32'h0, "post_rst_state");

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
